// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, slice mux selects and FSM state for the ALU slice sequencer
package alu_pkg;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LESS = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == ALUOP_AND) || (op == ALUOP_OR) || (op == ALUOP_ADD) ||
           (op == ALUOP_SUB) || (op == ALUOP_SLT);
  endfunction

  // SUB and SLT both compute a - b as a + ~b + 1.
  function automatic logic op_binvert(input logic [2:0] op);
    return (op == ALUOP_SUB) || (op == ALUOP_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - SLICE_W-wide and/or/adder/less datapath slice driven by the sequencer
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               binvert,
  input  logic               cin,
  input  logic [1:0]         sel,
  input  logic [SLICE_W-1:0] less,
  output logic [SLICE_W-1:0] result,
  output logic               cout
);

  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W-1:0] sum;

  always_comb begin
    b_eff       = binvert ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
    case (sel)
      SEL_AND: result = a & b_eff;
      SEL_OR:  result = a | b_eff;
      SEL_SUM: result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_slice_sequencer.sv
// rtl/alu_slice_sequencer.sv - walks one external ALU slice across DATA_W bits, with a
// second pass for SLT, and returns result/zero/overflow over a valid/ready response.
module alu_slice_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [DATA_W-1:0]  req_a,
  input  logic [DATA_W-1:0]  req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_zero,
  output logic               rsp_overflow,
  output logic               rsp_illegal,
  output logic [SLICE_W-1:0] slc_a,
  output logic [SLICE_W-1:0] slc_b,
  output logic               slc_binvert,
  output logic               slc_cin,
  output logic [1:0]         slc_sel,
  output logic [SLICE_W-1:0] slc_less,
  input  logic [SLICE_W-1:0] slc_result,
  input  logic               slc_cout
);

  localparam int NSLICES = DATA_W / SLICE_W;
  localparam int IDX_W   = $clog2(NSLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d, set_q, set_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, illegal_q, illegal_d;
  logic               sum_msb, ovf_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      set_q     <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      set_q     <= set_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    op_d        = op_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    set_d       = set_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    sum_msb     = 1'b0;
    ovf_raw     = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    slc_a       = '0;
    slc_b       = '0;
    slc_binvert = 1'b0;
    slc_cin     = 1'b0;
    slc_sel     = SEL_AND;
    slc_less    = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d       = req_a;
          b_d       = req_b;
          op_d      = req_op;
          idx_d     = '0;
          carry_d   = op_binvert(req_op);
          set_d     = 1'b0;
          result_d  = '0;
          ovf_d     = 1'b0;
          illegal_d = !op_is_legal(req_op);
          zero_d    = !op_is_legal(req_op);
          state_d   = op_is_legal(req_op) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        slc_a       = a_q[idx_q*SLICE_W +: SLICE_W];
        slc_b       = b_q[idx_q*SLICE_W +: SLICE_W];
        slc_binvert = op_binvert(op_q);
        slc_cin     = carry_q;
        slc_sel     = (op_q == ALUOP_AND) ? SEL_AND :
                      (op_q == ALUOP_OR)  ? SEL_OR  : SEL_SUM;
        result_d[idx_q*SLICE_W +: SLICE_W] = slc_result;
        carry_d = slc_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Sign of the true difference: sum MSB corrected by signed overflow.
          sum_msb = slc_result[SLICE_W-1];
          ovf_raw = (a_q[DATA_W-1] == (b_q[DATA_W-1] ^ op_binvert(op_q))) &&
                    (sum_msb != a_q[DATA_W-1]);
          set_d   = sum_msb ^ ovf_raw;
          idx_d   = '0;
          if (op_q == ALUOP_SLT) begin
            state_d = ST_LESS;
          end else begin
            ovf_d   = ovf_raw && ((op_q == ALUOP_ADD) || (op_q == ALUOP_SUB));
            zero_d  = (result_d == '0);
            state_d = ST_DONE;
          end
        end
      end
      ST_LESS: begin
        slc_sel     = SEL_LESS;
        slc_less[0] = (idx_q == '0) && set_q;
        result_d[idx_q*SLICE_W +: SLICE_W] = slc_result;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          zero_d  = (result_d == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_result   = (state_q == ST_DONE) ? result_q : '0;
  assign rsp_zero     = (state_q == ST_DONE) && zero_q;
  assign rsp_overflow = (state_q == ST_DONE) && ovf_q;
  assign rsp_illegal  = (state_q == ST_DONE) && illegal_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb/tb_alu_slice_sequencer.sv - directed bench closing the loop through alu_slice
module tb_alu_slice_sequencer;
  import alu_pkg::*;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = '0;
  logic [31:0]       req_a = '0;
  logic [31:0]       req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_result;
  logic              rsp_zero, rsp_overflow, rsp_illegal;
  logic [3:0]        slc_a, slc_b, slc_less, slc_result;
  logic              slc_binvert, slc_cin, slc_cout;
  logic [1:0]        slc_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_slice_sequencer #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
    .slc_a(slc_a), .slc_b(slc_b), .slc_binvert(slc_binvert), .slc_cin(slc_cin),
    .slc_sel(slc_sel), .slc_less(slc_less), .slc_result(slc_result), .slc_cout(slc_cout)
  );

  alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a(slc_a), .b(slc_b), .binvert(slc_binvert), .cin(slc_cin),
    .sel(slc_sel), .less(slc_less), .result(slc_result), .cout(slc_cout)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, check first-slice controls, latency and the response, optionally
  // holding rsp_ready low for hold cycles while checking the response stays put.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_ovf, input logic exp_ill, input int exp_lat,
                        input int hold);
    int lat;
    logic exp_inv;
    logic [1:0] exp_sel;
    logic [36:0] snap;
    exp_inv = (op == ALUOP_SUB) || (op == ALUOP_SLT);
    exp_sel = (op == ALUOP_AND) ? 2'b00 : (op == ALUOP_OR) ? 2'b01 : 2'b10;
    @(negedge clk);
    check_eq({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'b101; req_a = '1; req_b = '1;
    if (!exp_ill) begin
      check_eq({tag, ".slc0"}, 64'({slc_a, slc_b, slc_binvert, slc_cin, slc_sel}),
               64'({a[3:0], b[3:0], exp_inv, exp_inv, exp_sel}));
    end
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, ".result"}, 64'(rsp_result), 64'(exp_res));
    check_eq({tag, ".flags"}, 64'({rsp_zero, rsp_overflow, rsp_illegal}),
             64'({exp_zero, exp_ovf, exp_ill}));
    snap = {rsp_valid, req_ready, rsp_zero, rsp_overflow, rsp_illegal, rsp_result};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, ".hold"}, 64'({rsp_valid, req_ready, rsp_zero, rsp_overflow,
                                    rsp_illegal, rsp_result}), 64'(snap));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq({tag, ".release"}, 64'({rsp_valid, req_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    int seen;
    #1;
    check_eq("reset_async", 64'({req_ready, rsp_valid, rsp_result, slc_a, slc_b, slc_sel, slc_cin}),
             64'({1'b1, 1'b0, 32'h0, 4'h0, 4'h0, 2'b00, 1'b0}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outputs", 64'({req_ready, rsp_valid, slc_a, slc_b, slc_less, slc_binvert}),
             64'({1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0}));

    run_op("add_ovf",  ALUOP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 9, 0);
    run_op("sub_zero", ALUOP_SUB, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, 9, 0);
    run_op("sub_neg",  ALUOP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op("add_wrap", ALUOP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 9, 0);
    run_op("slt_ovf",  ALUOP_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 17, 0);
    run_op("slt_false",ALUOP_SLT, 32'h00000005, 32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b0, 1'b0, 17, 0);
    run_op("and",      ALUOP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op("or",       ALUOP_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op("illegal",  3'b011,    32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1, 5);

    // Reset mid-RUN of an ADD: everything drops at once and no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_op = ALUOP_ADD; req_a = 32'h11111111; req_b = 32'h22222222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("mid_run_busy", 64'({req_ready, slc_sel}), 64'({1'b0, 2'b10}));
    rst_n = 1'b0;
    #1;
    check_eq("mid_run_reset", 64'({rsp_valid, rsp_result, slc_a, slc_b, slc_sel, slc_cin, slc_binvert}),
             64'({1'b0, 32'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_ready", 64'(req_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_eq("post_reset_no_rsp", 64'(seen), 64'd0);

    run_op("add_after", ALUOP_ADD, 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0, 9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
